// File: rtl/lwe_op_engine_if.sv
// rtl/lwe_op_engine_if.sv - controller-side bundle for the LWE operation engine
interface lwe_op_engine_if #(
    parameter int PLAINTEXT_WIDTH  = 6,
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int DIMENSION        = 10,
    parameter int BIG_N            = 30
);
    localparam int CTW  = (DIMENSION + 1) * CIPHERTEXT_WIDTH;
    localparam int IDXW = (BIG_N > 1) ? $clog2(BIG_N) : 1;

    logic                              start;
    logic [1:0]                        op;
    logic [PLAINTEXT_WIDTH-1:0]        plaintext;
    logic [BIG_N-1:0]                  noise_select;
    logic [CTW-1:0]                    ct_a_in;
    logic [CTW-1:0]                    ct_b_in;
    logic [DIMENSION*CIPHERTEXT_WIDTH-1:0] secret_key;
    logic                              row_req;
    logic [IDXW-1:0]                   row_idx;
    logic                              row_valid;
    logic [CTW-1:0]                    row_data;
    logic                              busy;
    logic                              done;
    logic [CTW-1:0]                    ct_out;
    logic [PLAINTEXT_WIDTH-1:0]        pt_out;

    modport master (
        output start, op, plaintext, noise_select, ct_a_in, ct_b_in, secret_key,
        output row_valid, row_data,
        input  row_req, row_idx, busy, done, ct_out, pt_out
    );

    modport slave (
        input  start, op, plaintext, noise_select, ct_a_in, ct_b_in, secret_key,
        input  row_valid, row_data,
        output row_req, row_idx, busy, done, ct_out, pt_out
    );
endinterface

// File: rtl/lwe_op_engine.sv
// rtl/lwe_op_engine.sv - sequential LWE engine for encrypt, decrypt and homomorphic add
module lwe_op_engine #(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 10,
    parameter int DIMENSION          = 10,
    parameter int BIG_N              = 30,
    parameter int LANES              = 2
) (
    input  logic           clk,
    input  logic           rst,
    lwe_op_engine_if.slave bus
);
    localparam int PW    = PLAINTEXT_WIDTH;
    localparam int CW    = CIPHERTEXT_WIDTH;
    localparam int N     = DIMENSION;
    localparam int CTW   = (N + 1) * CW;
    localparam int IDXW  = (BIG_N > 1) ? $clog2(BIG_N) : 1;
    localparam int MBW   = $clog2(N + LANES + 1);
    localparam int SHIFT = CW - PW;
    localparam logic [CW-1:0]   HALF     = CW'(CIPHERTEXT_MODULUS / (2 * PLAINTEXT_MODULUS));
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BIG_N - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ENC_SCAN, S_ENC_FIN, S_DEC_MAC, S_DEC_FIN, S_ADD, S_DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   pt_q;
    logic [BIG_N-1:0] nsel_q;
    logic [CTW-1:0]  ct_a_q;
    logic [CTW-1:0]  ct_b_q;
    logic [CTW-1:0]  acc_q;
    logic [CW-1:0]   dot_q;
    logic [MBW-1:0]  mac_base;
    logic            row_req_q;
    logic [IDXW-1:0] row_idx_q;
    logic            busy_q;
    logic            done_q;
    logic [CTW-1:0]  ct_out_q;
    logic [PW-1:0]   pt_out_q;

    logic [CTW-1:0]  acc_plus_row;
    logic [CTW-1:0]  add_sum;
    logic [CTW-1:0]  enc_result;
    logic [CW-1:0]   dot_next;
    logic [2*CW-1:0] prod;
    logic [CW-1:0]   phase;
    logic [CW-1:0]   rounded;
    logic [IDXW-1:0] next_idx;
    logic            mac_last;

    assign bus.row_req = row_req_q;
    assign bus.row_idx = row_idx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ct_out  = ct_out_q;
    assign bus.pt_out  = pt_out_q;

    assign next_idx = row_idx_q + 1'b1;
    assign mac_last = (int'(mac_base) + LANES >= N);

    // Element-wise sums wrap naturally at q because each lane is exactly CW bits.
    always_comb begin
        acc_plus_row = '0;
        add_sum      = '0;
        for (int i = 0; i <= N; i++) begin
            acc_plus_row[i*CW +: CW] = acc_q[i*CW +: CW] + bus.row_data[i*CW +: CW];
            add_sum[i*CW +: CW]      = ct_a_q[i*CW +: CW] + ct_b_q[i*CW +: CW];
        end
        enc_result = acc_q;
        enc_result[N*CW +: CW] = acc_q[N*CW +: CW] + ({{(CW-PW){1'b0}}, pt_q} << SHIFT);
    end

    // Lanes whose index runs past the a-vector contribute nothing on the final pass.
    always_comb begin
        dot_next = dot_q;
        prod     = '0;
        for (int l = 0; l < LANES; l++) begin
            if (int'(mac_base) + l < N) begin
                prod = {{CW{1'b0}}, ct_a_q[(int'(mac_base) + l)*CW +: CW]}
                     * {{CW{1'b0}}, bus.secret_key[(int'(mac_base) + l)*CW +: CW]};
                dot_next = dot_next + CW'(prod);
            end
        end
    end

    assign phase   = ct_a_q[N*CW +: CW] - dot_q;
    assign rounded = phase + HALF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pt_q      <= '0;
            nsel_q    <= '0;
            ct_a_q    <= '0;
            ct_b_q    <= '0;
            acc_q     <= '0;
            dot_q     <= '0;
            mac_base  <= '0;
            row_req_q <= 1'b0;
            row_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ct_out_q  <= '0;
            pt_out_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && bus.op != 2'd3) begin
                        pt_q      <= bus.plaintext;
                        nsel_q    <= bus.noise_select;
                        ct_a_q    <= bus.ct_a_in;
                        ct_b_q    <= bus.ct_b_in;
                        acc_q     <= '0;
                        dot_q     <= '0;
                        mac_base  <= '0;
                        row_idx_q <= '0;
                        busy_q    <= 1'b1;
                        case (bus.op)
                            2'd0: begin
                                row_req_q <= bus.noise_select[0];
                                state     <= S_ENC_SCAN;
                            end
                            2'd1:    state <= S_DEC_MAC;
                            default: state <= S_ADD;
                        endcase
                    end
                end
                S_ENC_SCAN: begin
                    // row_req is pre-loaded for the index being entered, so a row
                    // returned in the same cycle retires without a stall.
                    if (!row_req_q || bus.row_valid) begin
                        if (row_req_q) begin
                            acc_q <= acc_plus_row;
                        end
                        if (row_idx_q == LAST_IDX) begin
                            row_req_q <= 1'b0;
                            row_idx_q <= '0;
                            state     <= S_ENC_FIN;
                        end else begin
                            row_idx_q <= next_idx;
                            row_req_q <= nsel_q[next_idx];
                        end
                    end
                end
                S_ENC_FIN: begin
                    ct_out_q <= enc_result;
                    done_q   <= 1'b1;
                    state    <= S_DONE;
                end
                S_DEC_MAC: begin
                    dot_q    <= dot_next;
                    mac_base <= mac_base + MBW'(LANES);
                    if (mac_last) begin
                        state <= S_DEC_FIN;
                    end
                end
                S_DEC_FIN: begin
                    pt_out_q <= PW'(rounded >> SHIFT);
                    done_q   <= 1'b1;
                    state    <= S_DONE;
                end
                S_ADD: begin
                    ct_out_q <= add_sum;
                    done_q   <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lwe_op_engine.sv
// tb/tb_lwe_op_engine.sv - self-checking bench for lwe_op_engine across several lane counts
module tb_lwe_op_engine;
    localparam int PW   = 6;
    localparam int CW   = 10;
    localparam int N    = 10;
    localparam int BN   = 30;
    localparam int CTW  = (N + 1) * CW;
    localparam int IDXW = 5;
    localparam int ND   = 4;
    localparam int Q    = 1024;
    localparam int P    = 64;
    localparam int LANE_TAB [ND] = '{2, 1, 3, 10};
    localparam int DEC_LAT  [ND] = '{7, 12, 6, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              start;
    logic [1:0]        op;
    logic [PW-1:0]     plaintext;
    logic [BN-1:0]     noise_select;
    logic [CTW-1:0]    ct_a_in;
    logic [CTW-1:0]    ct_b_in;
    logic [N*CW-1:0]   secret_key;
    logic              row_valid;
    logic [CTW-1:0]    row_data;

    logic              busy_w    [ND];
    logic              done_w    [ND];
    logic              row_req_w [ND];
    logic [IDXW-1:0]   row_idx_w [ND];
    logic [CTW-1:0]    ct_w      [ND];
    logic [PW-1:0]     pt_w      [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        lwe_op_engine_if #(.PLAINTEXT_WIDTH(PW), .CIPHERTEXT_WIDTH(CW),
                           .DIMENSION(N), .BIG_N(BN)) bus ();
        assign bus.start        = start;
        assign bus.op           = op;
        assign bus.plaintext    = plaintext;
        assign bus.noise_select = noise_select;
        assign bus.ct_a_in      = ct_a_in;
        assign bus.ct_b_in      = ct_b_in;
        assign bus.secret_key   = secret_key;
        assign bus.row_valid    = row_valid;
        assign bus.row_data     = row_data;
        assign busy_w[g]        = bus.busy;
        assign done_w[g]        = bus.done;
        assign row_req_w[g]     = bus.row_req;
        assign row_idx_w[g]     = bus.row_idx;
        assign ct_w[g]          = bus.ct_out;
        assign pt_w[g]          = bus.pt_out;
        lwe_op_engine #(.PLAINTEXT_MODULUS(P), .PLAINTEXT_WIDTH(PW),
                        .CIPHERTEXT_MODULUS(Q), .CIPHERTEXT_WIDTH(CW),
                        .DIMENSION(N), .BIG_N(BN), .LANES(LANE_TAB[g])) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    int             nvec = 0;
    int             nmis = 0;
    int             t      [ND];
    int             lat    [ND];
    int             done_t [ND];
    bit             active [ND];
    logic [CTW-1:0] exp_ct [ND];
    logic [CTW-1:0] nxt_ct [ND];
    logic [PW-1:0]  exp_pt [ND];
    logic [PW-1:0]  nxt_pt [ND];
    bit             enc_run = 1'b0;
    logic [BN-1:0]  enc_sel = '0;
    logic [BN-1:0]  seen = '0;
    int             stall = 0;
    logic [CTW-1:0] pk [BN];
    int             s_int [N];

    task automatic chk(input string name, input int k, input logic [CTW-1:0] act,
                       input logic [CTW-1:0] expv);
        nvec++;
        if (act !== expv) begin
            nmis++;
            $display("FAIL %s dut%0d got %0h want %0h", name, k, act, expv);
        end
    endtask

    function automatic int el(input logic [CTW-1:0] v, input int i);
        return int'(v[i*CW +: CW]);
    endfunction

    function automatic logic [CTW-1:0] m_add(input logic [CTW-1:0] a, input logic [CTW-1:0] b);
        logic [CTW-1:0] r = '0;
        for (int i = 0; i <= N; i++) r[i*CW +: CW] = CW'((el(a, i) + el(b, i)) % Q);
        return r;
    endfunction

    function automatic logic [PW-1:0] m_dec(input logic [CTW-1:0] ct, input logic [N*CW-1:0] sk);
        int dot = 0;
        int ph;
        for (int i = 0; i < N; i++) dot = (dot + el(ct, i) * el({{CW{1'b0}}, sk}, i)) % Q;
        ph = ((el(ct, N) - dot) % Q + Q) % Q;
        return PW'(((ph + Q / (2 * P)) / (Q / P)) % P);
    endfunction

    function automatic logic [CTW-1:0] m_enc(input logic [BN-1:0] sel, input logic [PW-1:0] m);
        int acc [N+1];
        logic [CTW-1:0] r = '0;
        for (int i = 0; i <= N; i++) acc[i] = 0;
        for (int rw = 0; rw < BN; rw++)
            if (sel[rw]) for (int i = 0; i <= N; i++) acc[i] = (acc[i] + el(pk[rw], i)) % Q;
        acc[N] = (acc[N] + int'(m) * (Q / P)) % Q;
        for (int i = 0; i <= N; i++) r[i*CW +: CW] = CW'(acc[i]);
        return r;
    endfunction

    task automatic launch(input logic [1:0] o, input int enc_stall);
        @(posedge clk); #2;
        op = o;
        start = 1'b1;
        stall = enc_stall;
        for (int k = 0; k < ND; k++) begin
            active[k] = 1'b1;
            t[k]      = -1;
            done_t[k] = -1;
            nxt_ct[k] = exp_ct[k];
            nxt_pt[k] = exp_pt[k];
            case (o)
                2'd0: begin
                    nxt_ct[k] = m_enc(noise_select, plaintext);
                    lat[k]    = BN + $countones(noise_select) * enc_stall + 2;
                end
                2'd1: begin
                    nxt_pt[k] = m_dec(ct_a_in, secret_key);
                    lat[k]    = (N + LANE_TAB[k] - 1) / LANE_TAB[k] + 2;
                end
                default: begin
                    nxt_ct[k] = m_add(ct_a_in, ct_b_in);
                    lat[k]    = 2;
                end
            endcase
        end
        if (o == 2'd0) begin
            enc_run = 1'b1;
            enc_sel = noise_select;
            seen    = '0;
        end
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic poke(input logic [1:0] o);
        @(posedge clk); #2;
        op = o;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((active[0] || active[1] || active[2] || active[3]) && n < 300) begin
            @(posedge clk);
            n++;
        end
        nvec++;
        if (n >= 300) begin
            nmis++;
            $display("FAIL op_timeout dut0 got busy want idle within 300 cycles");
            for (int k = 0; k < ND; k++) active[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
    endtask

    // Model advance and compare, once per cycle away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < ND; k++) begin
                logic eb, ed;
                if (rst) begin
                    active[k] = 1'b0;
                    exp_ct[k] = '0;
                    exp_pt[k] = '0;
                    enc_run   = 1'b0;
                end else if (active[k]) begin
                    t[k]++;
                    if (t[k] == lat[k]) begin
                        exp_ct[k] = nxt_ct[k];
                        exp_pt[k] = nxt_pt[k];
                    end
                end
                eb = active[k] && t[k] >= 1 && t[k] <= lat[k];
                ed = active[k] && t[k] == lat[k];
                chk("busy", k, busy_w[k], eb);
                chk("done", k, done_w[k], ed);
                chk("ct_out", k, ct_w[k], exp_ct[k]);
                chk("pt_out", k, pt_w[k], exp_pt[k]);
                if (done_w[k]) done_t[k] = t[k];
                if (!enc_run) begin
                    chk("row_req_idle", k, row_req_w[k], 1'b0);
                end else if (row_req_w[k]) begin
                    chk("row_req_sel", k, enc_sel[row_idx_w[k]], 1'b1);
                    if (k == 0) seen[row_idx_w[0]] = 1'b1;
                end
                if (active[k] && t[k] >= lat[k]) begin
                    active[k] = 1'b0;
                    if (k == 0) enc_run = 1'b0;
                end
            end
        end
    end

    // Public-key row server: stalls each request, and toggles junk valids while unrequested.
    initial begin
        int cnt = 0;
        row_valid = 1'b0;
        row_data  = '0;
        forever begin
            @(negedge clk);
            if (row_req_w[0]) begin
                if (cnt >= stall) begin
                    row_valid = 1'b1;
                    row_data  = pk[row_idx_w[0]];
                    cnt       = 0;
                end else begin
                    row_valid = 1'b0;
                    row_data  = '1;
                    cnt++;
                end
            end else begin
                row_valid = ~row_valid;
                row_data  = '1;
                cnt       = 0;
            end
        end
    end

    initial begin
        logic [CTW-1:0] lit;
        logic [4:0] bvals [3];
        int dot;
        start = 1'b0; op = '0; plaintext = '0; noise_select = '0;
        ct_a_in = '0; ct_b_in = '0; secret_key = '0;
        for (int r = 0; r < BN; r++) pk[r] = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i <= N; i++) begin
            ct_a_in[i*CW +: CW] = CW'(1000);
            ct_b_in[i*CW +: CW] = CW'(30);
        end
        launch(2'd2, 0);
        wait_idle();
        chk("add_elem0", 0, ct_w[0][CW-1:0], 6);
        chk("add_elem_b", 0, ct_w[0][N*CW +: CW], 6);
        chk("add_latency", 0, done_t[0], 2);

        secret_key = '0;
        for (int i = 0; i < N; i++) ct_a_in[i*CW +: CW] = CW'($urandom_range(0, Q - 1));
        bvals[0] = 5'd0; bvals[1] = 5'd1; bvals[2] = 5'd2;
        foreach (bvals[v]) begin
            int bv;
            int want;
            bv   = (v == 0) ? 53 : (v == 1) ? 56 : 1016;
            want = (v == 0) ? 3  : (v == 1) ? 4  : 0;
            ct_a_in[N*CW +: CW] = CW'(bv);
            launch(2'd1, 0);
            wait_idle();
            for (int k = 0; k < ND; k++) begin
                chk("dec_value", k, pt_w[k], want);
                chk("dec_latency", k, done_t[k], DEC_LAT[k]);
            end
        end

        poke(2'd3);
        repeat (4) @(posedge clk);

        plaintext = 6'd5;
        noise_select = '0;
        launch(2'd0, 0);
        repeat (10) @(posedge clk);
        poke(2'd2);
        wait_idle();
        lit = '0;
        lit[N*CW +: CW] = CW'(80);
        chk("enc_norows", 0, ct_w[0], lit);
        chk("enc_latency", 0, done_t[0], 32);

        for (int i = 0; i < N; i++) begin
            s_int[i] = $urandom_range(0, Q - 1);
            secret_key[i*CW +: CW] = CW'(s_int[i]);
        end
        for (int r = 0; r < BN; r++) begin
            dot = 0;
            for (int i = 0; i < N; i++) begin
                pk[r][i*CW +: CW] = CW'($urandom_range(0, Q - 1));
                dot = (dot + int'(pk[r][i*CW +: CW]) * s_int[i]) % Q;
            end
            pk[r][N*CW +: CW] = CW'((dot + $urandom_range(0, 2)) % Q);
        end
        plaintext = 6'd37;
        noise_select = '0;
        noise_select[2] = 1'b1;
        noise_select[7] = 1'b1;
        launch(2'd0, 3);
        wait_idle();
        chk("enc_rows_seen", 0, seen, noise_select);
        chk("enc_stall_latency", 0, done_t[0], 38);

        ct_a_in = exp_ct[0];
        launch(2'd1, 0);
        wait_idle();
        for (int k = 0; k < ND; k++) chk("roundtrip", k, pt_w[k], 37);

        launch(2'd1, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        for (int k = 0; k < ND; k++) begin
            chk("rst_pt", k, pt_w[k], 0);
            chk("rst_ct", k, ct_w[k], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
